// File: rtl/sel_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sel_mux_pkg
// Desc     : Shared defaults, selection-mode encodings and the select-width
//            helper used by sel_mux and rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sel_mux_pkg;

    localparam int DEFAULT_WIDTH    = 10;
    localparam int DEFAULT_CHANNELS = 4;

    // Selection modes
    localparam int MODE_SEL = 0;  // channel chosen by the external sel port
    localparam int MODE_RR  = 1;  // channel chosen by the round-robin arbiter

    // Width of a channel index; never narrower than one bit
    function automatic int sel_width(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

endpackage : sel_mux_pkg
`default_nettype wire

// File: rtl/sel_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin grant over CHANNELS requesters. The search starts at
//            the pointer and wraps; the pointer moves past the winner only
//            when the caller reports that the granted beat was taken.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sel_mux_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant
);

    localparam int c_pw = sel_width(CHANNELS);

    logic [c_pw-1:0] r_ptr;
    logic [c_pw-1:0] w_next_ptr;
    logic            w_found;

    // Channel index k steps above the pointer, wrapped into range
    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % CHANNELS;
    endfunction

    // First requester at or above the pointer wins; remember the slot after it
    always_comb begin
        grant      = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!w_found && req[wrap_idx(int'(r_ptr), k)]) begin
                grant[wrap_idx(int'(r_ptr), k)] = 1'b1;
                w_next_ptr = c_pw'((wrap_idx(int'(r_ptr), k) + 1) % CHANNELS);
                w_found    = 1'b1;
            end
        end
    end

    // Pointer only moves on an actual transfer so stalls keep the same winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sel_mux.sv
`default_nettype none
// ============================================================================
// Module   : sel_mux
// Desc     : Multi-channel valid/ready selector with a single registered
//            output stage. Channel choice is either an external select or a
//            round-robin arbiter, fixed at elaboration by MODE.
// Revision : 1.0 - initial release
// ============================================================================
module sel_mux
    import sel_mux_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int MODE     = MODE_SEL
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*WIDTH-1:0]      in_data,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [sel_width(CHANNELS)-1:0] sel,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [sel_width(CHANNELS)-1:0] out_chan,
    output logic                           sel_err
);

    localparam int c_sw = sel_width(CHANNELS);

    logic [CHANNELS-1:0] w_grant;
    logic                w_load_en;
    logic                w_xfer;
    logic                w_sel_bad;
    logic [WIDTH-1:0]    w_sel_data;
    logic [c_sw-1:0]     w_grant_idx;

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [c_sw-1:0]     r_out_chan;
    logic                r_sel_err;

    // The output register can take a new beat when empty or being drained
    assign w_load_en = !r_out_valid || out_ready;
    // Grants are only ever raised on valid channels, so any grant is a transfer
    assign w_xfer    = w_load_en && (|w_grant);
    // Gating with rst_n keeps every channel refused while reset is held
    assign in_ready  = (rst_n && w_load_en) ? w_grant : '0;

    if (MODE == MODE_RR) begin : g_rr
        // Select is ignored in this mode; fold it away explicitly
        logic w_unused_sel;
        assign w_unused_sel = ^sel;
        assign w_sel_bad    = 1'b0;

        rr_arbiter #(
            .CHANNELS (CHANNELS)
        ) u_rr_arbiter (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (in_valid),
            .advance (w_xfer),
            .grant   (w_grant)
        );
    end else begin : g_sel
        localparam logic [c_sw:0] c_channels = (c_sw+1)'(CHANNELS);

        // Only the selected channel may be granted, and only if it is valid
        always_comb begin
            w_grant = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                w_grant[i] = in_valid[i] && (sel == c_sw'(i));
            end
        end

        // An out-of-range select with pending data is flagged regardless of stall
        assign w_sel_bad = ({1'b0, sel} >= c_channels) && (|in_valid);
    end

    // Grant is one-hot, so OR-ing masked channels picks the winner without a wide index
    always_comb begin
        w_sel_data  = '0;
        w_grant_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_sel_data  = w_sel_data | in_data[i*WIDTH +: WIDTH];
                w_grant_idx = c_sw'(i);
            end
        end
    end

    // Output stage: load on transfer, clear valid on an idle load slot, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= w_sel_bad;
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_sel_data;
                    r_out_chan <= w_grant_idx;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign sel_err   = r_sel_err;

endmodule : sel_mux
`default_nettype wire

// File: tb/tb_sel_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_sel_mux
// Desc     : Scoreboard bench for sel_mux. Three instances run side by side:
//            SEL with 4 channels, RR with 4 channels, SEL with 3 channels.
//            A reference model predicts accepted beats and queues them; a
//            negedge monitor compares whatever the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sel_mux;
    import sel_mux_pkg::*;

    localparam int c_nu = 3;
    localparam int c_w  = 10;

    function automatic int ch_of(input int u);
        return (u == 2) ? 3 : 4;
    endfunction

    function automatic int mode_of(input int u);
        return (u == 1) ? MODE_RR : MODE_SEL;
    endfunction

    typedef struct packed {
        logic [c_w-1:0] data;
        logic [1:0]     chan;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [4*c_w-1:0] in_data   [c_nu];
    logic [3:0]       in_valid  [c_nu];
    logic [1:0]       sel       [c_nu];
    logic             out_ready [c_nu];
    wire  [3:0]       in_ready  [c_nu];
    wire  [c_w-1:0]   out_data  [c_nu];
    wire              out_valid [c_nu];
    wire  [1:0]       out_chan  [c_nu];
    wire              sel_err   [c_nu];

    beat_t sbq    [c_nu][$];
    bit    m_full [c_nu];
    int    m_ptr  [c_nu];
    bit    m_err  [c_nu];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_nu; g++) begin : g_dut
        localparam int c_ch = ch_of(g);
        wire [c_ch-1:0] w_ir;

        sel_mux #(
            .WIDTH    (c_w),
            .CHANNELS (c_ch),
            .MODE     (mode_of(g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (in_data[g][c_ch*c_w-1:0]),
            .in_valid  (in_valid[g][c_ch-1:0]),
            .in_ready  (w_ir),
            .sel       (sel[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_chan  (out_chan[g]),
            .sel_err   (sel_err[g])
        );

        assign in_ready[g] = 4'(w_ir);
    end

    task automatic cmp(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s unit%0d: got %0h, expected %0h (t=%0t)", name, u, act, exp, $time);
        end
    endtask

    task automatic set(input int u, input logic [3:0] v, input logic [1:0] s, input logic r);
        in_valid[u]  = v & 4'((1 << ch_of(u)) - 1);
        sel[u]       = s;
        out_ready[u] = r;
        in_data[u]   = 40'({$urandom(), $urandom()});
    endtask

    task automatic model_reset();
        for (int u = 0; u < c_nu; u++) begin
            m_full[u] = 1'b0;
            m_ptr[u]  = 0;
            m_err[u]  = 1'b0;
            sbq[u].delete();
        end
    endtask

    // Reference: decide which channel (if any) is accepted this cycle
    task automatic model_cycle(input int u);
        int         c       = ch_of(u);
        int         g       = -1;
        bit         load;
        bit         bad     = 1'b0;
        logic [3:0] exp_rdy = '0;
        load = !m_full[u] || out_ready[u];
        if (mode_of(u) == MODE_SEL) begin
            if (int'(sel[u]) >= c) bad = (in_valid[u] != 4'd0);
            else if (in_valid[u][sel[u]]) g = int'(sel[u]);
        end else begin
            for (int k = 0; k < c; k++) begin
                if (g < 0 && in_valid[u][(m_ptr[u] + k) % c]) g = (m_ptr[u] + k) % c;
            end
        end
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        cmp("in_ready", u, 64'(in_ready[u]), 64'(exp_rdy));
        if (load && g >= 0) begin
            sbq[u].push_back('{data: in_data[u][g*c_w +: c_w], chan: 2'(g)});
            if (mode_of(u) == MODE_RR) m_ptr[u] = (g + 1) % c;
        end
        m_full[u] = load ? (g >= 0) : 1'b1;
        m_err[u]  = bad;
    endtask

    task automatic run_cycle();
        #1;
        for (int u = 0; u < c_nu; u++) model_cycle(u);
        @(posedge clk);
        #1;
        for (int u = 0; u < c_nu; u++) begin
            cmp("out_valid", u, 64'(out_valid[u]), 64'(m_full[u]));
            cmp("sel_err", u, 64'(sel_err[u]), 64'(m_err[u]));
        end
    endtask

    task automatic check_reset_values();
        for (int u = 0; u < c_nu; u++) begin
            cmp("rst_out_valid", u, 64'(out_valid[u]), 64'd0);
            cmp("rst_out_data", u, 64'(out_data[u]), 64'd0);
            cmp("rst_out_chan", u, 64'(out_chan[u]), 64'd0);
            cmp("rst_sel_err", u, 64'(sel_err[u]), 64'd0);
            cmp("rst_in_ready", u, 64'(in_ready[u]), 64'd0);
        end
    endtask

    // Monitor: the oldest queued beat must be on the output while out_valid is high
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < c_nu; u++) begin
                if (out_valid[u]) begin
                    if (sbq[u].size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL out_beat unit%0d: got beat %0h, expected none (t=%0t)", u, out_data[u], $time);
                    end else begin
                        cmp("out_data", u, 64'(out_data[u]), 64'(sbq[u][0].data));
                        cmp("out_chan", u, 64'(out_chan[u]), 64'(sbq[u][0].chan));
                        if (out_ready[u]) void'(sbq[u].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int rr_seq [6] = '{0, 1, 2, 3, 0, 1};

        // Reset with every input active: nothing may be accepted or shown
        for (int u = 0; u < c_nu; u++) set(u, 4'hF, 2'd0, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int u = 0; u < c_nu; u++) set(u, 4'h0, 2'd0, 1'b1);

        // SEL basic transfer: channel 2 carrying 0x155
        set(0, 4'b0100, 2'd2, 1'b1);
        in_data[0][2*c_w +: c_w] = 10'h155;
        run_cycle();
        cmp("sel_basic_valid", 0, 64'(out_valid[0]), 64'd1);
        cmp("sel_basic_data", 0, 64'(out_data[0]), 64'h155);
        cmp("sel_basic_chan", 0, 64'(out_chan[0]), 64'd2);

        // Backpressure: hold 3 cycles with ch1 pending, then release
        set(0, 4'b0010, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            cmp("stall_data", 0, 64'(out_data[0]), 64'h155);
        end
        out_ready[0] = 1'b1;
        run_cycle();
        cmp("stall_release_chan", 0, 64'(out_chan[0]), 64'd1);
        set(0, 4'h0, 2'd0, 1'b1);

        // Round-robin with all channels valid
        set(1, 4'hF, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            cmp("rr_seq_chan", 1, 64'(out_chan[1]), 64'(rr_seq[i]));
        end

        // Wrap: pointer parked at 1, then requests on channels 0 and 3
        set(1, 4'b0001, 2'd0, 1'b1);
        run_cycle();
        set(1, 4'b1001, 2'd0, 1'b1);
        run_cycle();
        cmp("rr_wrap_first", 1, 64'(out_chan[1]), 64'd3);
        set(1, 4'b1001, 2'd0, 1'b1);
        run_cycle();
        cmp("rr_wrap_second", 1, 64'(out_chan[1]), 64'd0);
        set(1, 4'h0, 2'd0, 1'b1);

        // Out-of-range select on the 3-channel instance
        set(2, 4'b0001, 2'd3, 1'b1);
        run_cycle();
        cmp("sel_err_pulse", 2, 64'(sel_err[2]), 64'd1);
        cmp("sel_err_no_beat", 2, 64'(out_valid[2]), 64'd0);
        set(2, 4'h0, 2'd3, 1'b1);
        run_cycle();
        cmp("sel_err_clear", 2, 64'(sel_err[2]), 64'd0);

        // Randomized traffic on all instances
        repeat (400) begin
            for (int u = 0; u < c_nu; u++) begin
                set(u, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
            end
            run_cycle();
        end

        // Reset in the middle of a stall
        set(0, 4'b0010, 2'd1, 1'b0);
        set(1, 4'hF, 2'd0, 1'b0);
        set(2, 4'b0001, 2'd0, 1'b0);
        run_cycle();
        run_cycle();
        cmp("pre_reset_held", 0, 64'(out_valid[0]), 64'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set(0, 4'h0, 2'd0, 1'b1);
        set(1, 4'hF, 2'd0, 1'b1);
        set(2, 4'h0, 2'd0, 1'b1);
        run_cycle();
        cmp("post_reset_rr_valid", 1, 64'(out_valid[1]), 64'd1);
        cmp("post_reset_rr_chan", 1, 64'(out_chan[1]), 64'd0);
        set(1, 4'h0, 2'd0, 1'b1);
        repeat (3) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sel_mux
`default_nettype wire

// File: doc/sel_mux.md
SEL_MUX -- requirements
Module: sel_mux

Interface
REQ-001 Parameter WIDTH, default 10: data width per channel in bits, minimum 1.
REQ-002 Parameter CHANNELS, default 4: number of input channels, minimum 2; need not be a power of two.
REQ-003 Parameter MODE, default 0: selection mode; 0 = SEL (external select), 1 = RR (round-robin).
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1: one clock; reset is asynchronous and active-low.
REQ-006 Port in_data  in  CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  in  CHANNELS: per-channel data valid.
REQ-008 Port in_ready  out  CHANNELS: per-channel accept; at most one bit high per cycle.
REQ-009 Port sel  in  SW = max(1, clog2(CHANNELS)): channel select, used in SEL mode only, ignored in RR.
REQ-010 Port out_data  out  WIDTH: registered selected data.
REQ-011 Port out_valid  out  1: out_data holds an untaken beat.
REQ-012 Port out_ready  in  1: downstream accept.
REQ-013 Port out_chan  out  SW: source channel index of the current out_data.
REQ-014 Port sel_err  out  1: registered one-cycle pulse when sel >= CHANNELS while some in_valid is high.

Function
REQ-015 Output stage is one register; load_en = !out_valid || out_ready (full throughput, no bubble).
REQ-016 Transfer on channel i occurs when in_valid[i] && in_ready[i]; in_ready[i] = load_en && grant[i].
REQ-017 Latency: data accepted in cycle n appears on out_data with out_valid=1 in cycle n+1.
REQ-018 While out_valid && !out_ready, out_data, out_chan and out_valid are held stable and all in_ready are 0.
REQ-019 If load_en and there is no transfer, out_valid clears to 0 on the next edge; out_data keeps its last value.
REQ-020 SEL mode: grant[sel] = in_valid[sel] only; all other channels are refused even if valid.
REQ-021 SEL mode: when sel >= CHANNELS there is no grant; sel_err pulses if any in_valid is high, whether or not load_en is asserted.
REQ-022 RR mode: grant is the first valid channel searched upward from ptr, wrapping from CHANNELS-1 to 0.
REQ-023 RR mode: ptr updates to (granted+1) mod CHANNELS only on a transfer; a stall or no-valid cycle leaves ptr unchanged.
REQ-024 RR mode: sel_err is constant 0.
REQ-025 Input valid deasserting without a transfer is legal; no state changes.

Reset
REQ-026 On rst_n low, asynchronously: out_valid=0, out_data=0, out_chan=0, sel_err=0, ptr=0.
REQ-027 in_ready is 0 for every channel while rst_n is low.
REQ-028 Reset mid-operation discards any held output beat; after release, the first RR grant searches from channel 0.

Structure
REQ-029 Package sel_mux_pkg holds DEFAULT_WIDTH=10, DEFAULT_CHANNELS=4, and the mode constants MODE_SEL=0 and MODE_RR=1.
REQ-030 Round-robin grant plus pointer lives in sub-module rr_arbiter (parameter CHANNELS; inputs req, advance; output one-hot grant); it is instantiated only when MODE=1.

Verification
REQ-031 SEL, CHANNELS=4: sel=2, in_valid=4'b0100, in_data ch2=10'h155, out_ready=1 -> in_ready=4'b0100; the next cycle has out_valid=1, out_data=10'h155 and out_chan=2.
REQ-032 Backpressure: out_valid=1 with out_ready=0 for 3 cycles while ch1 is valid -> in_ready=0 and out_data is stable for all 3 cycles; out_ready=1 -> the ch1 beat is accepted the same cycle.
REQ-033 RR, CHANNELS=4, all valid, out_ready=1 for 6 cycles -> out_chan sequence is 0,1,2,3,0,1.
REQ-034 RR: valid=4'b1001 with ptr=1 -> channel 3 is granted; the next grant is channel 0, which wraps.
REQ-035 SEL, CHANNELS=3: sel=3 with in_valid=3'b001 -> no transfer; sel_err=1 for one cycle; out_valid=0.
REQ-036 Assert rst_n=0 mid-stall with out_valid=1 -> all outputs reach their reset values immediately; after release, RR with all channels valid grants channel 0.
